// File: rtl/btn_pkg.sv
// btn_pkg: shared types and constants for the push-button debounce path.
//   btn_state_e             - debounce FSM state, 2-bit encoding
//   BTN_DEBOUNCE_CYCLES_27M - 10 ms at 27 MHz
//   BTN_LONG_CYCLES_27M     - 1 s at 27 MHz
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int BTN_DEBOUNCE_CYCLES_27M = 270000;
  localparam int BTN_LONG_CYCLES_27M     = 27000000;

endpackage

// File: rtl/btn_timer.sv
// btn_timer: saturating up-counter with synchronous clear and count enable.
//   clk   - clock
//   rst   - synchronous active-high reset (count -> 0)
//   clr   - synchronous clear, wins over en
//   en    - count enable; the count holds once it reaches MAX
//   count - current count, $clog2(MAX+1) bits
//   done  - terminal flag, high while count == MAX
module btn_timer #(
  parameter int MAX = 1,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         done
);

  localparam logic [W-1:0] CNT_MAX = W'(MAX);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                          cnt_d = '0;
    else if (en && cnt_q != CNT_MAX)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;
  assign done  = (cnt_q == CNT_MAX);

endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: debounce + event stage for one synchronized push button.
//   CLk         - system clock
//   RESET       - synchronous active-high reset
//   iIntBtn     - synchronized button level (polarity set by ACTIVE_LOW)
//   oBtnLevel   - debounced pressed level, 1 = pressed
//   oBtnPress   - one-cycle pulse when a press is accepted
//   oBtnRelease - one-cycle pulse when a release is accepted
//   oBtnLong    - one-cycle long-press pulse
// Optional feature macro: BTN_DEBOUNCE_LONGPRESS_EN builds the hold counter
// and the long-press pulse; without it oBtnLong is tied low.
// A new level is accepted DEBOUNCE_CYCLES cycles after it first appears.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_CYCLES_27M,
  parameter int LONG_CYCLES     = BTN_LONG_CYCLES_27M,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic CLk,
  input  logic RESET,
  input  logic iIntBtn,
  output logic oBtnLevel,
  output logic oBtnPress,
  output logic oBtnRelease,
  output logic oBtnLong
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  // With a one-cycle debounce the WAIT states are skipped entirely.
  localparam bit DEB_ONE = (DEBOUNCE_CYCLES == 1);

  btn_state_e state_d, state_q;
  logic level_d, level_q;
  logic press_d, press_q;
  logic release_d, release_q;
  logic deb_clr, deb_en;
  logic hold_clr, hold_run;
  logic [DW-1:0] deb_cnt;
  logic unused_deb_done;
  logic pressed;

  assign pressed = iIntBtn ^ ACTIVE_LOW;

  btn_timer #(.MAX(DEBOUNCE_CYCLES), .W(DW)) u_deb_timer (
    .clk   (CLk),
    .rst   (RESET),
    .clr   (deb_clr),
    .en    (deb_en),
    .count (deb_cnt),
    .done  (unused_deb_done)
  );

  // Debounce counter is 0 in IDLE/HELD; entering a WAIT state counts it to 1.
  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    deb_clr   = 1'b0;
    deb_en    = 1'b0;
    hold_clr  = 1'b0;
    hold_run  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pressed) begin
          if (DEB_ONE) begin
            state_d  = HELD;
            level_d  = 1'b1;
            press_d  = 1'b1;
            hold_clr = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            deb_en  = 1'b1;
          end
        end
      end
      PRESS_WAIT: begin
        if (!pressed) begin
          state_d = IDLE;
          deb_clr = 1'b1;
        end else if (deb_cnt == DEB_LAST) begin
          state_d  = HELD;
          level_d  = 1'b1;
          press_d  = 1'b1;
          deb_clr  = 1'b1;
          hold_clr = 1'b1;
        end else begin
          deb_en = 1'b1;
        end
      end
      HELD: begin
        hold_run = 1'b1;
        if (!pressed) begin
          if (DEB_ONE) begin
            state_d   = IDLE;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            state_d = RELEASE_WAIT;
            deb_en  = 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to pressed is not a release; hold count keeps going.
        hold_run = 1'b1;
        if (pressed) begin
          state_d = HELD;
          deb_clr = 1'b1;
        end else if (deb_cnt == DEB_LAST) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
          deb_clr   = 1'b1;
        end else begin
          deb_en = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        level_d = 1'b0;
        deb_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLk) begin
    if (RESET) begin
      state_q   <= IDLE;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign oBtnLevel   = level_q;
  assign oBtnPress   = press_q;
  assign oBtnRelease = release_q;

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hold_cnt;
  logic unused_hold_done;
  logic long_d, long_q;

  btn_timer #(.MAX(LONG_CYCLES), .W(HW)) u_hold_timer (
    .clk   (CLk),
    .rst   (RESET),
    .clr   (hold_clr),
    .en    (hold_run),
    .count (hold_cnt),
    .done  (unused_hold_done)
  );

  // Fires on the step to LONG_CYCLES; saturation makes it once per press.
  // A release accepted on that same edge wins and suppresses it.
  always_comb begin
    long_d = hold_run && (hold_cnt == HOLD_LAST) && !release_d;
  end

  always_ff @(posedge CLk) begin
    if (RESET) long_q <= 1'b0;
    else       long_q <= long_d;
  end

  assign oBtnLong = long_q;
`else
  logic unused_long;
  assign unused_long = (LONG_CYCLES < 1) ^ hold_clr ^ hold_run;
  assign oBtnLong    = 1'b0;
`endif

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Debounce and event stage for one push button, placed directly downstream of the two-flop button synchronizer. It takes the already-synchronized, active-low button level and filters contact bounce with a stability counter. It produces a clean pressed level, single-cycle press and release pulses, and optionally a single-cycle long-press pulse. Buttons feed user logic only through this block.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 270000: consecutive cycles a new level must persist before it is accepted (10 ms at 27 MHz). Must be ≥ 1.
- LONG_CYCLES, 27000000: cycles of debounced hold, counted from press acceptance, before the long-press pulse (1 s at 27 MHz). Must be ≥ 1.
- ACTIVE_LOW, 1: 1 means input level 0 is pressed; 0 means input level 1 is pressed.

Ports:
- CLk, input, 1: system clock; the only clock.
- RESET, input, 1: synchronous, active-high reset.
- iIntBtn, input, 1: synchronized button level (output of the synchronizer stage).
- oBtnLevel, output, 1: debounced pressed level (1 = pressed).
- oBtnPress, output, 1: one-cycle pulse when a press is accepted.
- oBtnRelease, output, 1: one-cycle pulse when a release is accepted.
- oBtnLong, output, 1: one-cycle pulse on long press; constant 0 when the feature is compiled out.

## Operation
- Input normalization: pressed = iIntBtn XOR ACTIVE_LOW.
- FSM states:
  - IDLE (stable released)
  - PRESS_WAIT
  - HELD (stable pressed)
  - RELEASE_WAIT
- IDLE:
  - pressed = 1 → go to PRESS_WAIT with the debounce counter set to 1.
- PRESS_WAIT:
  - pressed = 0 → return to IDLE and clear the counter (any bounce restarts qualification).
  - pressed = 1 and counter = DEBOUNCE_CYCLES−1 → go to HELD, assert oBtnLevel, pulse oBtnPress, clear the hold counter.
  - otherwise → increment the counter.
- HELD:
  - pressed = 0 → go to RELEASE_WAIT with the counter set to 1.
  - The hold counter increments every cycle in HELD and RELEASE_WAIT, saturating at LONG_CYCLES.
- RELEASE_WAIT:
  - pressed = 1 → return to HELD and clear the debounce counter. The hold counter continues; a bounce is not a release.
  - pressed = 0 and counter = DEBOUNCE_CYCLES−1 → go to IDLE, deassert oBtnLevel, pulse oBtnRelease.
  - otherwise → increment the counter.
- DEBOUNCE_CYCLES = 1: the FSM passes straight through the WAIT states. Acceptance happens on the first cycle the new level is seen.
- Press and release pulses are never asserted in the same cycle, and each is followed by at least DEBOUNCE_CYCLES cycles without the opposite pulse.
- Counter widths:
  - debounce counter: $clog2(DEBOUNCE_CYCLES+1)
  - hold counter: $clog2(LONG_CYCLES+1)
  - Neither counter wraps: the debounce counter is bounded by the FSM, and the hold counter saturates.

## Timing
- All outputs are registered.
- Reset values:
  - oBtnLevel = 0, oBtnPress = 0, oBtnRelease = 0, oBtnLong = 0.
  - FSM = IDLE, both counters = 0.
- RESET has priority over every transition. Asserting it mid-debounce or mid-hold discards all progress.
- If the button is held through reset deassertion, a press is accepted after DEBOUNCE_CYCLES cycles, with a normal oBtnPress pulse.
- Latency:
  - Count from the first cycle pressed = 1 at the input (cycle 0). oBtnLevel and oBtnPress are visible in cycle DEBOUNCE_CYCLES.
  - Release latency is symmetric.
- End-to-end from the pad: add the synchronizer's 2 cycles.
- Each pulse is exactly 1 cycle wide.

## Configuration
- Macro: BTN_DEBOUNCE_LONGPRESS_EN.
- Defined:
  - The hold counter is built.
  - oBtnLong pulses once when the hold counter reaches LONG_CYCLES, at most once per accepted press.
  - The pulse is suppressed if release has been accepted first.
  - Release after a long press still produces oBtnRelease.
- Undefined:
  - No hold counter logic is instantiated.
  - oBtnLong is tied to 0 and LONG_CYCLES is ignored.

## Structure
- Shared package btn_pkg contains:
  - the FSM state typedef (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT), 2-bit encoding
  - default constants BTN_DEBOUNCE_CYCLES_27M = 270000 and BTN_LONG_CYCLES_27M = 27000000
- Sub-module btn_timer: parameterized saturating up-counter with clear, enable and a terminal flag. It is instantiated for the debounce counter and, under the macro, for the hold counter.

## Test plan
Bench parameters: DEBOUNCE_CYCLES = 4, LONG_CYCLES = 20, ACTIVE_LOW = 1, macro defined unless stated.
- Reset with iIntBtn = 1 for 10 cycles → all outputs 0, no pulses.
- Drive iIntBtn to 0 at cycle 0 and hold → oBtnPress is high for exactly 1 cycle and oBtnLevel rises, both in cycle 4. Releasing to 1 → oBtnRelease is high for 1 cycle, 4 cycles later.
- Bounce the input as 0,0,0,1,0,0,0,1 repeated → no press ever accepted. Then hold 0 for 4 cycles → exactly 1 press pulse.
- Hold pressed → oBtnLong is high for exactly 1 cycle, 20 cycles after oBtnPress. A 2-cycle release glitch before that point does not reset the hold count or pulse oBtnRelease.
- Assert RESET at cycle 2 of PRESS_WAIT with the input held at 0 → outputs 0, then press accepted 4 cycles after RESET deasserts.
- Macro undefined, hold pressed for 50 cycles → oBtnLong stays 0; press and release behave identically to the defined case.
